facto_core_param: RTL and testbench

- Memory-mapped factorial accelerator on the 64-bit slave bus. Computes n! for an OP_W-bit operand into a 2*OP_W-bit accumulator.
- Successor to the fixed-64-bit factorial core, adding:
  - parametrised operand width and multiplier radix;
  - overflow detection;
  - busy status;
  - clean abort.
- Sits beside other bus slaves. Raises a level interrupt to the interrupt controller.

---
 rtl/facto_pkg.sv | 39 +++
 rtl/facto_shift_mul.sv | 100 ++++++++++
 rtl/facto_core_param.sv | 202 ++++++++++++++++++++
 tb/tb_facto_core_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/facto_pkg.sv
//------------------------------------------------------------------------------
// Module  : facto_pkg
// Brief   : Shared constants for the factorial accelerator: register word
//           indices, CTRL/STATUS bit positions and FSM state encoding.
// Revision: 1.0 - initial parametrised release
//------------------------------------------------------------------------------
`default_nettype none

package facto_pkg;

  // Register word indices (s_addr[7:3])
  localparam logic [4:0] C_REG_CTRL     = 5'd0;
  localparam logic [4:0] C_REG_STATUS   = 5'd1;
  localparam logic [4:0] C_REG_INTR_EN  = 5'd2;
  localparam logic [4:0] C_REG_OPERAND  = 5'd3;
  localparam logic [4:0] C_REG_RESULT_H = 5'd4;
  localparam logic [4:0] C_REG_RESULT_L = 5'd5;
  localparam logic [4:0] C_REG_CYCLES   = 5'd6;

  // CTRL bit positions
  localparam int C_CTRL_START = 0;
  localparam int C_CTRL_CLEAR = 1;

  // STATUS bit positions
  localparam int C_STAT_DONE = 0;
  localparam int C_STAT_BUSY = 1;
  localparam int C_STAT_OVF  = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } facto_state_e;

endpackage : facto_pkg

`default_nettype wire

// File: rtl/facto_shift_mul.sv
//------------------------------------------------------------------------------
// Module  : facto_shift_mul
// Brief   : Shift-add multiplier, 2*OP_W x OP_W -> 3*OP_W, retiring MUL_BITS
//           multiplier bits per cycle. The first digit is consumed in the
//           start cycle so the done pulse lands OP_W/MUL_BITS cycles after
//           start (start cycle counted as cycle 1 of OP_W/MUL_BITS+1).
// Revision: 1.0 - initial parametrised release
//------------------------------------------------------------------------------
`default_nettype none

module facto_shift_mul
  import facto_pkg::*;
#(
  parameter int OP_W     = 64,
  parameter int MUL_BITS = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mul_start,
  input  logic                mul_abort,
  input  logic [2*OP_W-1:0]   multiplicand,
  input  logic [OP_W-1:0]     multiplier,
  output logic [3*OP_W-1:0]   product,
  output logic                mul_done
);

  localparam int C_STEPS  = OP_W / MUL_BITS;
  localparam int C_CNT_W  = $clog2(C_STEPS + 1);
  localparam int C_PROD_W = 3 * OP_W;

  logic                 r_busy;
  logic                 r_done;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_PROD_W-1:0]  r_acc;
  logic [C_PROD_W-1:0]  r_mcand;
  logic [OP_W-1:0]      r_mplier;

  logic [C_PROD_W-1:0]  w_mcand_ext;
  logic [C_PROD_W-1:0]  w_first;
  logic [C_PROD_W-1:0]  w_step;

  // Partial product of a shifted multiplicand and one MUL_BITS-wide digit
  function automatic logic [C_PROD_W-1:0] f_partial(
    input logic [C_PROD_W-1:0] mcand,
    input logic [MUL_BITS-1:0] digit
  );
    logic [C_PROD_W-1:0] sum;
    sum = '0;
    for (int b = 0; b < MUL_BITS; b++) begin
      if (digit[b]) begin
        sum = sum + (mcand << b);
      end
    end
    return sum;
  endfunction

  assign w_mcand_ext = {{OP_W{1'b0}}, multiplicand};
  assign w_first     = f_partial(w_mcand_ext, multiplier[MUL_BITS-1:0]);
  assign w_step      = f_partial(r_mcand, r_mplier[MUL_BITS-1:0]);

  assign product  = r_acc;
  assign mul_done = r_done;

  // Shift-add datapath: load with the first digit on start, then one digit
  // per cycle; abort drops back to idle on the next edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_done <= 1'b0;
      if (mul_abort) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (mul_start) begin
        r_busy   <= 1'b1;
        r_acc    <= w_first;
        r_mcand  <= w_mcand_ext << MUL_BITS;
        r_mplier <= multiplier >> MUL_BITS;
        r_cnt    <= C_CNT_W'(C_STEPS - 1);
      end else if (r_busy) begin
        r_acc    <= r_acc + w_step;
        r_mcand  <= r_mcand << MUL_BITS;
        r_mplier <= r_mplier >> MUL_BITS;
        r_cnt    <= r_cnt - 1'b1;
        if (r_cnt == C_CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule : facto_shift_mul

`default_nettype wire

// File: rtl/facto_core_param.sv
//------------------------------------------------------------------------------
// Module  : facto_core_param
// Brief   : Memory-mapped factorial accelerator on the 64-bit slave bus.
//           Computes n! of an OP_W-bit operand into a 2*OP_W-bit accumulator
//           with overflow detection, busy status, abort and level interrupt.
//           Optional CYCLES counter at word 6 when FACTO_CYCLE_CNT_EN is
//           defined; otherwise word 6 reads 0.
// Revision: 1.0 - initial parametrised release
//------------------------------------------------------------------------------
`default_nettype none

module facto_core_param
  import facto_pkg::*;
#(
  parameter int OP_W     = 64,
  parameter int MUL_BITS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_addr,
  input  logic [63:0] s_din,
  output logic [63:0] s_dout,
  output logic        interrupt
);

  localparam logic [2*OP_W-1:0] C_ACC_ONE = (2*OP_W)'(1);

  facto_state_e          r_state;
  logic [OP_W-1:0]       r_k;
  logic [2*OP_W-1:0]     r_acc;
  logic                  r_done;
  logic                  r_ovf;
  logic                  r_mul_start;
  logic                  r_intr_en;
  logic [OP_W-1:0]       r_operand;

  logic [4:0]            w_word;
  logic                  w_wr;
  logic                  w_ctrl_wr;
  logic                  w_start;
  logic                  w_clear;
  logic                  w_busy;
  logic [2:0]            w_status;
  logic [63:0]           w_rdata;
  logic [31:0]           w_cycles;
  logic [3*OP_W-1:0]     w_product;
  logic                  w_mul_done;
  logic                  w_unused_bus;

  // Byte-lane and high address bits carry no information for this slave
  assign w_unused_bus = ^{s_addr[15:8], s_addr[2:0], s_din};

  assign w_word    = s_addr[7:3];
  assign w_wr      = s_sel & s_wr;
  assign w_ctrl_wr = w_wr & (w_word == C_REG_CTRL);
  // Clear has priority: a combined start+clear write only clears
  assign w_clear   = w_ctrl_wr & s_din[C_CTRL_CLEAR];
  assign w_start   = w_ctrl_wr & s_din[C_CTRL_START] & ~s_din[C_CTRL_CLEAR];
  assign w_busy    = (r_state == ST_LOAD) || (r_state == ST_MUL);
  assign interrupt = r_done & r_intr_en;

  facto_shift_mul #(
    .OP_W     (OP_W),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk          (clk),
    .reset_n      (reset_n),
    .mul_start    (r_mul_start),
    .mul_abort    (w_clear),
    .multiplicand (r_acc),
    .multiplier   (r_k),
    .product      (w_product),
    .mul_done     (w_mul_done)
  );

  // Sequencer: latch k, multiply ACC by k down to 2, stop early on overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_acc       <= C_ACC_ONE;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_mul_start <= 1'b0;
    end else if (w_clear) begin
      r_state     <= ST_IDLE;
      r_acc       <= C_ACC_ONE;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_mul_start <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_k     <= r_operand;
            r_acc   <= C_ACC_ONE;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_k <= OP_W'(1)) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_mul_start <= 1'b1;
            r_state     <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_mul_start <= 1'b0;
          if (w_mul_done) begin
            if (w_product[3*OP_W-1:2*OP_W] != '0) begin
              // Keep the last in-range accumulator value
              r_ovf   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_acc   <= w_product[2*OP_W-1:0];
              r_k     <= r_k - 1'b1;
              r_state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FACTO_CYCLE_CNT_EN
  logic [31:0] r_cycles;

  // Busy-cycle counter: zeroed on accepted start or clear, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycles <= '0;
    end else if (w_clear || (w_start && (r_state == ST_IDLE))) begin
      r_cycles <= '0;
    end else if (w_busy && (r_cycles != '1)) begin
      r_cycles <= r_cycles + 1'b1;
    end
  end

  assign w_cycles = r_cycles;
`else
  assign w_cycles = '0;
`endif

  // STATUS word assembled from bit-position constants
  always_comb begin
    w_status              = '0;
    w_status[C_STAT_DONE] = r_done;
    w_status[C_STAT_BUSY] = w_busy;
    w_status[C_STAT_OVF]  = r_ovf;
  end

  // Read mux; CTRL and unmapped words return zero
  always_comb begin
    w_rdata = '0;
    case (w_word)
      C_REG_STATUS:   w_rdata = 64'(w_status);
      C_REG_INTR_EN:  w_rdata = 64'(r_intr_en);
      C_REG_OPERAND:  w_rdata = 64'(r_operand);
      C_REG_RESULT_H: w_rdata = 64'(r_acc[2*OP_W-1:OP_W]);
      C_REG_RESULT_L: w_rdata = 64'(r_acc[OP_W-1:0]);
      C_REG_CYCLES:   w_rdata = 64'(w_cycles);
      default:        w_rdata = '0;
    endcase
  end

  // Bus-writable registers and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_intr_en <= 1'b0;
      r_operand <= '0;
      s_dout    <= '0;
    end else begin
      if (w_wr && (w_word == C_REG_INTR_EN)) begin
        r_intr_en <= s_din[0];
      end
      if (w_wr && (w_word == C_REG_OPERAND)) begin
        r_operand <= s_din[OP_W-1:0];
      end
      if (s_sel && !s_wr) begin
        s_dout <= w_rdata;
      end else begin
        s_dout <= '0;
      end
    end
  end

endmodule : facto_core_param

`default_nettype wire

// File: tb/tb_facto_core_param.sv
//------------------------------------------------------------------------------
// Module  : tb_facto_core_param
// Brief   : Self-checking bench for facto_core_param. Instance A uses
//           OP_W=64/MUL_BITS=1, instance B uses OP_W=16/MUL_BITS=4.
//           Read expectations are queued when a read is issued and compared
//           when the registered read data appears.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_facto_core_param;

  logic        clk;
  logic        reset_n;

  logic        a_sel, a_wr, a_irq;
  logic [15:0] a_addr;
  logic [63:0] a_din, a_dout;
  logic        b_sel, b_wr, b_irq;
  logic [15:0] b_addr;
  logic [63:0] b_din, b_dout;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];

  localparam logic [4:0] W_CTRL = 5'd0, W_STATUS = 5'd1, W_INTR_EN = 5'd2,
                         W_OPERAND = 5'd3, W_RES_H = 5'd4, W_RES_L = 5'd5,
                         W_CYCLES = 5'd6;

  facto_core_param #(.OP_W(64), .MUL_BITS(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .s_sel(a_sel), .s_wr(a_wr),
    .s_addr(a_addr), .s_din(a_din), .s_dout(a_dout), .interrupt(a_irq)
  );

  facto_core_param #(.OP_W(16), .MUL_BITS(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .s_sel(b_sel), .s_wr(b_wr),
    .s_addr(b_addr), .s_din(b_din), .s_dout(b_dout), .interrupt(b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int dut, input logic sel, input logic wr,
                       input logic [4:0] word, input logic [63:0] din);
    if (dut == 0) begin
      a_sel = sel; a_wr = wr; a_addr = {8'h00, word, 3'b000}; a_din = din;
    end else begin
      b_sel = sel; b_wr = wr; b_addr = {8'h00, word, 3'b000}; b_din = din;
    end
  endtask

  function automatic logic [63:0] dout_of(input int dut);
    return (dut == 0) ? a_dout : b_dout;
  endfunction

  function automatic logic irq_of(input int dut);
    return (dut == 0) ? a_irq : b_irq;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write lands on the next rising edge; returns 1 time unit after it
  task automatic bus_write(input int dut, input logic [4:0] word, input logic [63:0] data);
    @(negedge clk);
    drive(dut, 1'b1, 1'b1, word, data);
    @(posedge clk);
    #1;
    drive(dut, 1'b0, 1'b0, 5'd0, 64'd0);
  endtask

  // Read sampled on the next rising edge; data compared just after it
  task automatic bus_read(input int dut, input logic [4:0] word,
                          input logic [63:0] exp, input string tag);
    logic [63:0] e;
    string       t;
    @(negedge clk);
    drive(dut, 1'b1, 1'b0, word, 64'd0);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    drive(dut, 1'b0, 1'b0, 5'd0, 64'd0);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, dout_of(dut), e);
  endtask

  task automatic wait_irq(input int dut, input int budget, input string tag);
    int n;
    n = 0;
    while (!irq_of(dut) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 64'(irq_of(dut)), 64'd1);
  endtask

  // Reference factorial with overflow stop on a 2*w-bit accumulator
  function automatic void fact_model(input int n, input int w,
                                     output logic [127:0] acc, output logic ovf);
    logic [255:0] p;
    acc = 128'd1;
    ovf = 1'b0;
    for (int k = n; k >= 2; k--) begin
      p = 256'(acc) * 256'(k);
      if ((p >> (2 * w)) != 256'd0) begin
        ovf = 1'b1;
        break;
      end
      acc = p[127:0];
    end
  endfunction

  initial begin
    logic [127:0] m_acc;
    logic         m_ovf;
    logic [63:0]  exp_cyc;

`ifdef FACTO_CYCLE_CNT_EN
    exp_cyc = 64'd133;
`else
    exp_cyc = 64'd0;
`endif

    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 5'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 64'd0);
    wait_cycles(3);
    check("rst_dout_a", a_dout, 64'd0);
    check("rst_irq_a", 64'(a_irq), 64'd0);
    check("rst_dout_b", b_dout, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset register values
    bus_read(0, W_STATUS,  64'd0, "rst_status");
    bus_read(0, W_RES_L,   64'd1, "rst_res_l");
    bus_read(0, W_RES_H,   64'd0, "rst_res_h");
    bus_read(0, W_OPERAND, 64'd0, "rst_operand");
    bus_read(0, W_INTR_EN, 64'd0, "rst_intr_en");
    bus_read(0, W_CTRL,    64'd0, "ctrl_reads_zero");
    wait_cycles(1);
    check("no_read_dout", a_dout, 64'd0);

    // 5! with exact completion timing
    bus_write(0, W_OPERAND, 64'd5);
    bus_read(0, W_OPERAND, 64'd5, "operand_rb");
    bus_write(0, W_CTRL, 64'h1);
    wait_cycles(264);
    bus_read(0, W_STATUS, 64'h2, "n5_busy_at_265");
    bus_read(0, W_STATUS, 64'h1, "n5_done_at_266");
    bus_read(0, W_RES_L,  64'd120, "n5_res_l");
    bus_read(0, W_RES_H,  64'd0, "n5_res_h");
    check("n5_irq_disabled", 64'(a_irq), 64'd0);
    bus_write(0, W_INTR_EN, 64'd1);
    check("n5_irq_enabled", 64'(a_irq), 64'd1);
    bus_write(0, W_CTRL, 64'h1);
    bus_read(0, W_RES_L, 64'd120, "start_in_done_ignored");
    bus_write(0, W_CTRL, 64'h2);
    check("irq_drops_on_clear", 64'(a_irq), 64'd0);

    // n = 0 and n = 1: single busy cycle
    bus_write(0, W_OPERAND, 64'd0);
    bus_write(0, W_CTRL, 64'h1);
    bus_read(0, W_STATUS, 64'h2, "n0_busy");
    bus_read(0, W_STATUS, 64'h1, "n0_done");
    bus_read(0, W_RES_L,  64'd1, "n0_res_l");
    bus_write(0, W_CTRL, 64'h2);
    bus_write(0, W_OPERAND, 64'd1);
    bus_write(0, W_CTRL, 64'h1);
    bus_read(0, W_STATUS, 64'h2, "n1_busy");
    bus_read(0, W_STATUS, 64'h1, "n1_done");
    bus_read(0, W_RES_L,  64'd1, "n1_res_l");
    bus_write(0, W_CTRL, 64'h2);

    // 34! fits exactly in 128 bits
    fact_model(34, 64, m_acc, m_ovf);
    bus_write(0, W_OPERAND, 64'd34);
    bus_write(0, W_CTRL, 64'h1);
    wait_irq(0, 3000, "n34_irq");
    bus_read(0, W_STATUS, {63'd0, 1'b1} | (m_ovf ? 64'h4 : 64'h0), "n34_status");
    bus_read(0, W_RES_H, m_acc[127:64], "n34_res_h");
    bus_read(0, W_RES_L, m_acc[63:0],   "n34_res_l");
    bus_write(0, W_CTRL, 64'h2);

    // 35! overflows: ACC holds the last in-range partial product
    fact_model(35, 64, m_acc, m_ovf);
    bus_write(0, W_OPERAND, 64'd35);
    bus_write(0, W_CTRL, 64'h1);
    wait_irq(0, 3000, "n35_irq");
    bus_read(0, W_STATUS, 64'h5, "n35_status_ovf");
    bus_read(0, W_RES_H, m_acc[127:64], "n35_res_h");
    bus_read(0, W_RES_L, m_acc[63:0],   "n35_res_l");
    bus_write(0, W_CTRL, 64'h2);
    bus_read(0, W_STATUS, 64'h0, "n35_clear_status");

    // Abort mid-computation
    bus_write(0, W_OPERAND, 64'd20);
    bus_write(0, W_CTRL, 64'h1);
    wait_cycles(29);
    bus_write(0, W_CTRL, 64'h2);
    bus_read(0, W_STATUS, 64'h0, "abort_status");
    bus_read(0, W_RES_L,  64'd1, "abort_res_l");
    check("abort_irq", 64'(a_irq), 64'd0);

    // 3! with OPERAND rewritten and a stray start while busy
    bus_write(0, W_OPERAND, 64'd3);
    bus_write(0, W_CTRL, 64'h1);
    wait_cycles(10);
    bus_write(0, W_OPERAND, 64'd7);
    bus_write(0, W_CTRL, 64'h1);
    wait_irq(0, 400, "n3_irq");
    bus_read(0, W_RES_L,   64'd6, "n3_res_l");
    bus_read(0, W_OPERAND, 64'd7, "operand_updated_while_busy");
    bus_read(0, W_CYCLES,  exp_cyc, "n3_cycles");

    // Instance B: OP_W=16, MUL_BITS=4
    bus_read(1, W_RES_L, 64'd1, "b_rst_res_l");
    bus_write(1, W_OPERAND, 64'hFFFF_FFFF_FFFF_0009);
    bus_read(1, W_OPERAND, 64'h0009, "b_operand_upper_ignored");
    bus_write(1, W_CTRL, 64'h1);
    wait_cycles(48);
    bus_read(1, W_STATUS, 64'h2, "b_n9_busy_at_49");
    bus_read(1, W_STATUS, 64'h1, "b_n9_done_at_50");
    bus_read(1, W_RES_H, 64'h0005, "b_n9_res_h");
    bus_read(1, W_RES_L, 64'h8980, "b_n9_res_l");
    bus_write(1, W_INTR_EN, 64'd1);
    check("b_irq", 64'(b_irq), 64'd1);
    bus_write(1, W_CTRL, 64'h2);
    bus_write(1, W_CTRL, 64'h3);
    bus_read(1, W_STATUS, 64'h0, "b_start_clear_idle");
    wait_cycles(5);
    bus_read(1, W_STATUS, 64'h0, "b_still_idle");
    check("b_irq_low", 64'(b_irq), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_facto_core_param

`default_nettype wire
